// File: rtl/eink_panel_rx.sv
// Panel-side receiver for the e-ink source/gate timing bus: rebuilds addressed pixel writes, line/frame events and sticky errors.
// Define EINK_RX_SYNC_EN for a 2-flop input synchronizer (bus asynchronous to clk); otherwise a single register stage.
module eink_panel_rx #(
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COL_W-1:0] XCL_NUM,
    input  logic [ROW_W-1:0] CKV_NUM,
    input  logic             xcl,
    input  logic             xstl,
    input  logic             xle,
    input  logic             ckv,
    input  logic             spv,
    input  logic             mode,
    input  logic [15:0]      data,
    input  logic             err_clr,
    output logic             pix_valid,
    output logic [COL_W-1:0] pix_col,
    output logic [ROW_W-1:0] pix_row,
    output logic [15:0]      pix_data,
    output logic             line_done,
    output logic [ROW_W-1:0] line_row,
    output logic             frame_active,
    output logic             frame_done,
    output logic [2:0]       err
);

    typedef enum logic [1:0] {IDLE, ARMED, LINE_WAIT, SHIFT} state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic        xcl_c, xstl_c, xle_c, ckv_c, spv_c, mode_c;
    logic        xcl_p, xle_p, ckv_p, mode_p;
    logic [15:0] data_c;

`ifdef EINK_RX_SYNC_EN
    logic        xcl_m, xstl_m, xle_m, ckv_m, spv_m, mode_m;
    logic [15:0] data_m;

    // NOTE: non-blocking assignments make each flop sample the previous stage's old value, forming a real shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {xcl_m, xstl_m, xle_m, ckv_m, spv_m, mode_m} <= '0;
            {xcl_c, xstl_c, xle_c, ckv_c, spv_c, mode_c} <= '0;
            data_m <= '0;
            data_c <= '0;
        end else begin
            {xcl_m, xstl_m, xle_m, ckv_m, spv_m, mode_m} <= {xcl, xstl, xle, ckv, spv, mode};
            {xcl_c, xstl_c, xle_c, ckv_c, spv_c, mode_c} <= {xcl_m, xstl_m, xle_m, ckv_m, spv_m, mode_m};
            data_m <= data;
            data_c <= data_m;
        end
    end
`else
    // NOTE: non-blocking assignments make each flop sample the previous stage's old value, forming a real shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {xcl_c, xstl_c, xle_c, ckv_c, spv_c, mode_c} <= '0;
            data_c <= '0;
        end else begin
            {xcl_c, xstl_c, xle_c, ckv_c, spv_c, mode_c} <= {xcl, xstl, xle, ckv, spv, mode};
            data_c <= data;
        end
    end
`endif

    // Previous-value stage, only for the pins whose edges matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {xcl_p, xle_p, ckv_p, mode_p} <= '0;
        end else begin
            {xcl_p, xle_p, ckv_p, mode_p} <= {xcl_c, xle_c, ckv_c, mode_c};
        end
    end

    logic             xcl_rise, xle_rise, ckv_rise, mode_rise, mode_fall;
    logic             abort, in_line, do_xcl, do_write, do_ovf, do_latch, short_line;
    logic [COL_W-1:0] col_after;
    logic [ROW_W-1:0] row_after;
    logic [2:0]       new_err;

    always_comb begin
        xcl_rise   = xcl_c & ~xcl_p;
        xle_rise   = xle_c & ~xle_p;
        ckv_rise   = ckv_c & ~ckv_p;
        mode_rise  = mode_c & ~mode_p;
        mode_fall  = ~mode_c & mode_p;
        abort      = mode_fall && (state != IDLE);
        in_line    = (state == LINE_WAIT) || (state == SHIFT);
        do_xcl     = (state == SHIFT) && xcl_rise && !abort;
        do_write   = do_xcl && (col < XCL_NUM);
        do_ovf     = do_xcl && !(col < XCL_NUM);
        do_latch   = in_line && xle_rise && !abort;
        // A pixel written in the latch cycle still counts toward the line length.
        col_after  = col + COL_W'(do_write);
        row_after  = row + ROW_W'(1);
        short_line = do_latch && (col_after != XCL_NUM);
        new_err    = {abort, short_line, do_ovf};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            pix_valid    <= 1'b0;
            pix_col      <= '0;
            pix_row      <= '0;
            pix_data     <= '0;
            line_done    <= 1'b0;
            line_row     <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            err          <= '0;
        end else begin
            pix_valid  <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            // A fresh error in the clearing cycle survives the clear.
            err <= (err_clr ? 3'b000 : err) | new_err;

            if (do_write) begin
                pix_valid <= 1'b1;
                pix_col   <= col;
                pix_row   <= row;
                pix_data  <= data_c;
            end

            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        row          <= '0;
                        col          <= '0;
                        frame_active <= 1'b0;
                        if (mode_rise) state <= ARMED;
                    end
                    ARMED: begin
                        if (ckv_rise && !spv_c) begin
                            state        <= LINE_WAIT;
                            frame_active <= 1'b1;
                        end
                    end
                    LINE_WAIT, SHIFT: begin
                        if (do_latch) begin
                            line_done <= 1'b1;
                            line_row  <= row;
                            col       <= '0;
                            row       <= row_after;
                            if (row_after == CKV_NUM) begin
                                frame_done <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= LINE_WAIT;
                            end
                        end else begin
                            col <= col_after;
                            if (state == LINE_WAIT && !xstl_c) state <= SHIFT;
                            else if (state == SHIFT && xstl_c) state <= LINE_WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eink_panel_rx.sv
// Directed self-checking bench for eink_panel_rx; expected latency follows EINK_RX_SYNC_EN.
module tb_eink_panel_rx;

`ifdef EINK_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  xcl_num, ckv_num;
    logic        xcl, xstl, xle, ckv, spv, mode, err_clr;
    logic [15:0] data;
    logic        pix_valid, line_done, frame_active, frame_done;
    logic [9:0]  pix_col, pix_row, line_row;
    logic [15:0] pix_data;
    logic [2:0]  err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eink_panel_rx #(.COL_W(10), .ROW_W(10)) dut (
        .clk(clk), .rst(rst), .XCL_NUM(xcl_num), .CKV_NUM(ckv_num),
        .xcl(xcl), .xstl(xstl), .xle(xle), .ckv(ckv), .spv(spv), .mode(mode),
        .data(data), .err_clr(err_clr),
        .pix_valid(pix_valid), .pix_col(pix_col), .pix_row(pix_row), .pix_data(pix_data),
        .line_done(line_done), .line_row(line_row), .frame_active(frame_active),
        .frame_done(frame_done), .err(err)
    );

    // Event logs, written only here; the main sequence indexes them from a saved base.
    logic [35:0] wr_q[$];
    logic [9:0]  ld_q[$];
    int          fd_cnt = 0;
    int          fd_bad = 0;

    always @(negedge clk) begin
        if (pix_valid) wr_q.push_back({pix_row, pix_col, pix_data});
        if (line_done) ld_q.push_back(line_row);
        if (frame_done) begin
            fd_cnt++;
            if (!line_done || !frame_active) fd_bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] exp_wr(input int r, input int c);
        logic [15:0] d;
        d = 16'hA000 + 16'(r * 16 + c);
        return {10'(r), 10'(c), d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        mode = 1'b1; tick(3);
        spv  = 1'b0; tick(2);
        ckv  = 1'b1; tick(3);
        ckv  = 1'b0; spv = 1'b1; tick(3);
    endtask

    task automatic end_frame();
        tick(2); mode = 1'b0; tick(4);
    endtask

    task automatic send_words(input int r, input int n);
        for (int c = 0; c < n; c++) begin
            data = 16'hA000 + 16'(r * 16 + c); tick(1);
            xcl  = 1'b1; tick(2);
            xcl  = 1'b0; tick(2);
        end
    endtask

    task automatic latch_line();
        xstl = 1'b1; tick(2);
        xle  = 1'b1; tick(2);
        xle  = 1'b0; tick(3);
    endtask

    task automatic send_line(input int r, input int n);
        xstl = 1'b0; tick(3);
        send_words(r, n);
        latch_line();
    endtask

    task automatic clear_err();
        err_clr = 1'b1; tick(1);
        err_clr = 1'b0; tick(1);
    endtask

    int wb, lb, fb, lat, hits;

    initial begin
        rst = 1'b1; xcl = 0; xstl = 1; xle = 0; ckv = 0; spv = 1; mode = 0;
        data = '0; err_clr = 0; xcl_num = 10'd4; ckv_num = 10'd3;
        tick(3);
        check("reset_flags", {pix_valid, line_done, frame_done, frame_active, err}, 0);
        check("reset_buses", {pix_col, pix_row, pix_data, line_row}, 0);
        rst = 1'b0; tick(3);

        // Latency: one-pixel, one-line frame.
        xcl_num = 10'd1; ckv_num = 10'd1;
        fb = fd_cnt;
        start_frame();
        xstl = 1'b0; tick(3);
        data = 16'h5A5A; tick(1);
        xcl = 1'b1; lat = 0; hits = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (pix_valid) begin
                hits++;
                if (lat == 0) lat = k;
            end
        end
        check("latency", lat, LAT);
        check("lat_pulse_width", hits, 1);
        check("lat_pixel", {pix_row, pix_col, pix_data}, {10'd0, 10'd0, 16'h5A5A});
        tick(1); xcl = 1'b0; tick(2);
        latch_line();
        check("lat_frame_done", fd_cnt - fb, 1);
        check("lat_err", err, 3'b000);
        end_frame();

        // Nominal 4x3 frame.
        xcl_num = 10'd4; ckv_num = 10'd3;
        wb = wr_q.size(); lb = ld_q.size(); fb = fd_cnt;
        start_frame();
        check("nom_frame_active", frame_active, 1'b1);
        for (int r = 0; r < 3; r++) send_line(r, 4);
        check("nom_active_drop", frame_active, 1'b0);
        check("nom_writes", wr_q.size() - wb, 12);
        for (int i = 0; i < 12 && wb + i < wr_q.size(); i++)
            check($sformatf("nom_wr%0d", i), wr_q[wb + i], exp_wr(i / 4, i % 4));
        check("nom_lines", ld_q.size() - lb, 3);
        for (int i = 0; i < 3 && lb + i < ld_q.size(); i++)
            check($sformatf("nom_line_row%0d", i), ld_q[lb + i], i);
        check("nom_frame_done", fd_cnt - fb, 1);
        check("nom_fd_align", fd_bad, 0);
        check("nom_err", err, 3'b000);
        check("nom_hold", {pix_valid, pix_row, pix_col, pix_data, line_row},
              {1'b0, 10'd2, 10'd3, 16'hA023, 10'd2});
        end_frame();

        // Overflow: 6 words into a 4-word line.
        ckv_num = 10'd1;
        wb = wr_q.size(); lb = ld_q.size(); fb = fd_cnt;
        start_frame();
        send_line(0, 6);
        check("ovf_writes", wr_q.size() - wb, 4);
        if (wr_q.size() >= wb + 4) check("ovf_last_wr", wr_q[wb + 3], exp_wr(0, 3));
        check("ovf_err", err, 3'b001);
        check("ovf_line_done", ld_q.size() - lb, 1);
        check("ovf_frame_done", fd_cnt - fb, 1);
        end_frame();
        clear_err();
        check("err_clear", err, 3'b000);

        // Short line followed by a full line.
        ckv_num = 10'd2;
        wb = wr_q.size(); lb = ld_q.size();
        start_frame();
        send_line(0, 2);
        send_line(1, 4);
        check("short_writes", wr_q.size() - wb, 6);
        if (wr_q.size() >= wb + 6) begin
            check("short_wr1", wr_q[wb + 1], exp_wr(0, 1));
            check("short_next", wr_q[wb + 2], exp_wr(1, 0));
            check("short_last", wr_q[wb + 5], exp_wr(1, 3));
        end
        check("short_err", err, 3'b010);
        check("short_lines", ld_q.size() - lb, 2);
        end_frame();
        clear_err();

        // Abort after line 0 of 3, then a clean frame.
        ckv_num = 10'd3;
        fb = fd_cnt;
        start_frame();
        send_line(0, 4);
        mode = 1'b0; tick(4);
        check("abort_err", err, 3'b100);
        check("abort_no_fd", fd_cnt - fb, 0);
        check("abort_inactive", frame_active, 1'b0);
        clear_err();
        wb = wr_q.size(); fb = fd_cnt;
        start_frame();
        for (int r = 0; r < 3; r++) send_line(r, 4);
        check("post_abort_writes", wr_q.size() - wb, 12);
        if (wr_q.size() > wb) check("post_abort_first", wr_q[wb], exp_wr(0, 0));
        check("post_abort_fd", fd_cnt - fb, 1);
        check("post_abort_err", err, 3'b000);
        end_frame();

        // Asynchronous reset in the middle of a line.
        start_frame();
        xstl = 1'b0; tick(3);
        send_words(0, 2);
        rst = 1'b1; #1;
        check("rst_flags", {pix_valid, line_done, frame_done, frame_active, err}, 0);
        check("rst_buses", {pix_col, pix_row, pix_data, line_row}, 0);
        xstl = 1'b1; mode = 1'b0; tick(3);
        rst = 1'b0; tick(3);
        ckv_num = 10'd1;
        wb = wr_q.size(); fb = fd_cnt;
        start_frame();
        send_line(0, 4);
        check("rst_next_writes", wr_q.size() - wb, 4);
        if (wr_q.size() > wb) check("rst_next_first", wr_q[wb], exp_wr(0, 0));
        check("rst_next_fd", fd_cnt - fb, 1);
        check("rst_next_err", err, 3'b000);
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eink_panel_rx.md
# eink_panel_rx

Panel-side receiver for the e-ink source/gate timing bus. It oversamples XCL/XSTL/XLE/CKV/SPV/MODE/DATA on the system clock and reconstructs the pixel stream as addressed writes (row, column, 16-bit word). It raises line and frame events and flags protocol errors. It sits opposite the panel timing generator, either as a loopback checker in the FPGA or as a capture front-end feeding a frame buffer.

## Interface
Parameters:
- COL_W, 10, column index width
- ROW_W, 10, row index width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- XCL_NUM  in  COL_W  data words per line; valid range 1..2^COL_W-1
- CKV_NUM  in  ROW_W  lines per frame; valid range 1..2^ROW_W-1
- xcl  in  1  source shift clock; data captured on rising edge
- xstl  in  1  source start, active-low shift enable
- xle  in  1  line latch; rising edge ends a line
- ckv  in  1  gate clock
- spv  in  1  gate start, active-low
- mode  in  1  output enable; low outside a frame
- data  in  16  source data
- err_clr  in  1  clears err
- pix_valid  out  1  one-cycle pixel write strobe
- pix_col  out  COL_W  column of the pixel write
- pix_row  out  ROW_W  row of the pixel write
- pix_data  out  16  captured word
- line_done  out  1  one-cycle pulse on line latch
- line_row  out  ROW_W  row just latched
- frame_active  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse after the last line
- err  out  3  sticky flags: [0] overflow, [1] short line, [2] abort

## Operation
- Input stage:
  - All inputs are registered, then delayed one more stage for edge detection.
  - data travels in the same pipeline as xcl, so the captured word is the one present with the xcl rising edge.
  - Edge detection: rise = cur & ~prev; fall = ~cur & prev.
- FSM states: IDLE, ARMED, LINE_WAIT, SHIFT.
- IDLE:
  - row = 0, col = 0, frame_active = 0.
  - A mode rise goes to ARMED.
- ARMED:
  - A ckv rise while spv = 0 goes to LINE_WAIT and sets frame_active = 1.
- LINE_WAIT:
  - xstl = 0 goes to SHIFT.
  - An xle rise performs a line latch.
- SHIFT, on each xcl rise:
  - If col < XCL_NUM: pix_valid = 1, pix_col = col, pix_row = row, pix_data = captured word, then col++.
  - Otherwise: the word is dropped and err[0] is set.
  - xstl = 1 returns to LINE_WAIT.
  - An xle rise performs a line latch.
- Line latch:
  - line_done = 1, line_row = row.
  - err[1] is set if col != XCL_NUM.
  - col = 0, row++.
  - If the new row == CKV_NUM: frame_done = 1, go to IDLE. Otherwise go to LINE_WAIT.
- Abort: a mode fall in ARMED, LINE_WAIT or SHIFT sets err[2] and goes to IDLE. No frame_done is issued.
- An xcl rise outside SHIFT is ignored, with no error. ckv rises after frame start are ignored.
- Simultaneous events:
  - xcl rise and xle rise in the same cycle: the pixel is written first (counted), then the line is latched.
  - Abort beats everything else in the same cycle; the pixel is not written.
- err bits are sticky. err_clr clears them, but a new error arriving in the same cycle wins.
- Reset clears all state and pipeline registers. Every output resets to 0; the FSM resets to IDLE.

## Timing
- Let N be the first clk edge that samples a pin transition. Registered outputs respond at:
  - N+2 with EINK_RX_SYNC_EN defined.
  - N+1 without it.
- pix_valid, line_done and frame_done are exactly one cycle wide.
- pix_col, pix_row and pix_data are valid only while pix_valid = 1 and hold their last value otherwise.
- line_row holds until the next line_done.
- Pin timing requirements: each xcl high and low phase lasts at least 2 clk with the macro (1 without). data is stable from 1 clk before to 1 clk after the xcl rise.
- frame_done coincides with the last line_done. frame_active drops in the following cycle.

## Configuration
- EINK_RX_SYNC_EN:
  - Defined: inputs xcl, xstl, xle, ckv, spv and mode pass through a 2-flop synchronizer; data is delayed to match. Use this when the bus is asynchronous to clk. Latency is N+2.
  - Undefined: a single register stage, for buses synchronous to clk. Latency is N+1.

## Test plan
- Nominal frame, XCL_NUM = 4, CKV_NUM = 3:
  - Stimulus: mode pulse, spv low at ckv rise, 3 lines of 4 xcl with data 0xA000 + row*16 + col, xle after each line.
  - Required: 12 pix_valid writes with the correct row/col/data; line_done with line_row = 0, 1, 2; frame_done once; err = 0.
- Overflow, XCL_NUM = 4:
  - Stimulus: 6 xcl rises in one line.
  - Required: 4 writes (col 0..3), err = 3'b001, err[1] = 0, line_done still asserted.
- Short line:
  - Stimulus: 2 xcl rises, then xle.
  - Required: writes at col 0..1, err[1] = 1, next line starts at col 0 with row + 1.
- Abort:
  - Stimulus: mode driven low after line 1 of 3.
  - Required: err[2] = 1, no frame_done, frame_active = 0; a following full frame is captured correctly starting at row 0.
- Reset mid-SHIFT:
  - Stimulus: rst asserted at col 2.
  - Required: all outputs 0 immediately and FSM in IDLE; a following frame starts at row 0, col 0.
- Latency:
  - Stimulus: single xcl rise with the macro defined, then repeated without it.
  - Required: pix_valid at N+2 with the macro, N+1 without.
